// File: rtl/minesweeper_pkg.sv
// Shared types and screen constants for the minesweeper video path.
// Used by the plot arbiter and its clear sweeper.
package minesweeper_pkg;

  typedef enum logic [1:0] {
    CLEAR    = 2'd0,
    IDLE     = 2'd1,
    GRANT_B  = 2'd2,
    GRANT_WL = 2'd3
  } arb_state_t;

  localparam int          SCREEN_W   = 160;
  localparam int          SCREEN_H   = 120;
  localparam int          COLOUR_W   = 3;
  localparam logic [1:0]  WL_PLAYING = 2'b00;

endpackage

// File: rtl/clear_sweeper.sv
// Raster counter that walks every pixel of the screen once per sweep,
// wrapping back to (0,0) after the final pixel.
module clear_sweeper #(
  parameter int CX_W = 8,
  parameter int CY_W = 7,
  parameter int W    = 160,
  parameter int H    = 120
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            en,
  output logic [CX_W-1:0] cx,
  output logic [CY_W-1:0] cy,
  output logic            last
);

  logic [CX_W-1:0] cx_d, cx_q;
  logic [CY_W-1:0] cy_d, cy_q;
  logic            row_end;
  logic            col_end;

  assign row_end = (cx_q == CX_W'(W - 1));
  assign col_end = (cy_q == CY_W'(H - 1));

  // start wins over en so a restart always lands exactly on (0,0)
  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (start) begin
      cx_d = '0;
      cy_d = '0;
    end else if (en) begin
      if (row_end) begin
        cx_d = '0;
        cy_d = col_end ? '0 : cy_q + CY_W'(1);
      end else begin
        cx_d = cx_q + CX_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign cx   = cx_q;
  assign cy   = cy_q;
  assign last = row_end && col_end;

endmodule

// File: rtl/plot_arbiter.sv
// Owns the VGA plot port: clears the screen after reset or a game-result
// change, then grants whole draw bursts to the board or win/lose drawer.
module plot_arbiter
  import minesweeper_pkg::*;
#(
  parameter int                  X_W          = 8,
  parameter int                  Y_W          = 7,
  parameter int                  SCREEN_W     = minesweeper_pkg::SCREEN_W,
  parameter int                  SCREEN_H     = minesweeper_pkg::SCREEN_H,
  parameter int                  X_OFF        = 1,
  parameter int                  Y_OFF        = 1,
  parameter logic [COLOUR_W-1:0] CLEAR_COLOUR = 3'b000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          wl,
  input  logic                b_req,
  input  logic [X_W-1:0]      b_x,
  input  logic [Y_W-1:0]      b_y,
  input  logic [COLOUR_W-1:0] b_colour,
  input  logic                b_plot,
  input  logic                b_done,
  output logic                b_grant,
  input  logic                wl_req,
  input  logic [X_W-1:0]      wl_x,
  input  logic [Y_W-1:0]      wl_y,
  input  logic [COLOUR_W-1:0] wl_colour,
  input  logic                wl_plot,
  input  logic                wl_done,
  output logic                wl_grant,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                plot_out,
  output logic                clearing
);

  arb_state_t          state_d, state_q;
  logic [1:0]          wl_prev_q;
  logic                wl_chg;
  logic [X_W-1:0]      x_out_d, x_out_q;
  logic [Y_W-1:0]      y_out_d, y_out_q;
  logic [COLOUR_W-1:0] colour_out_d, colour_out_q;
  logic                plot_out_d, plot_out_q;
  logic [X_W-1:0]      cx;
  logic [Y_W-1:0]      cy;
  logic                sweep_last;
  logic                sweep_en;

  assign wl_chg   = (wl != wl_prev_q);
  assign sweep_en = (state_q == CLEAR) && !wl_chg;

  clear_sweeper #(
    .CX_W (X_W),
    .CY_W (Y_W),
    .W    (SCREEN_W),
    .H    (SCREEN_H)
  ) u_sweeper (
    .clock (clock),
    .reset (reset),
    .start (wl_chg),
    .en    (sweep_en),
    .cx    (cx),
    .cy    (cy),
    .last  (sweep_last)
  );

  // A result change aborts whatever is happening, including its pixel
  always_comb begin
    state_d      = state_q;
    x_out_d      = x_out_q;
    y_out_d      = y_out_q;
    colour_out_d = colour_out_q;
    plot_out_d   = 1'b0;
    if (wl_chg) begin
      state_d = CLEAR;
    end else begin
      case (state_q)
        CLEAR: begin
          x_out_d      = cx;
          y_out_d      = cy;
          colour_out_d = CLEAR_COLOUR;
          plot_out_d   = 1'b1;
          if (sweep_last) state_d = IDLE;
        end
        IDLE: begin
          if (wl != WL_PLAYING && wl_req)      state_d = GRANT_WL;
          else if (wl == WL_PLAYING && b_req) state_d = GRANT_B;
        end
        GRANT_B: begin
          x_out_d      = b_x + X_W'(X_OFF);
          y_out_d      = b_y + Y_W'(Y_OFF);
          colour_out_d = b_colour;
          plot_out_d   = b_plot;
          if (b_done) state_d = IDLE;
        end
        GRANT_WL: begin
          x_out_d      = wl_x + X_W'(X_OFF);
          y_out_d      = wl_y + Y_W'(Y_OFF);
          colour_out_d = wl_colour;
          plot_out_d   = wl_plot;
          if (wl_done) state_d = IDLE;
        end
        default: state_d = CLEAR;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    wl_prev_q <= wl;
    if (reset) begin
      state_q      <= CLEAR;
      x_out_q      <= '0;
      y_out_q      <= '0;
      colour_out_q <= '0;
      plot_out_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_out_q      <= x_out_d;
      y_out_q      <= y_out_d;
      colour_out_q <= colour_out_d;
      plot_out_q   <= plot_out_d;
    end
  end

  assign b_grant    = (state_q == GRANT_B);
  assign wl_grant   = (state_q == GRANT_WL);
  assign clearing   = (state_q == CLEAR);
  assign x_out      = x_out_q;
  assign y_out      = y_out_q;
  assign colour_out = colour_out_q;
  assign plot_out   = plot_out_q;

endmodule

// File: doc/plot_arbiter.md
Name: plot_arbiter

Overview:
- Shares the single VGA adapter plot port (x, y, colour, plot) between the board drawer and the win/lose drawer. The top-level currently uses a combinational mux for this.
- Grants whole draw bursts to one requester at a time, using a req/grant/done handshake.
- Inserts a full-screen clear sweep after reset and on every win/lose state change.
- Registers the pixel stream and applies the +1 screen offset.
- Sits between drawBoard/drawWinLose and vga_adapter, in the CLOCK_50 domain.

Parameters:
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- SCREEN_W, 160, clear sweep width in pixels.
- SCREEN_H, 120, clear sweep height in pixels.
- X_OFF, 1, offset added to requester x.
- Y_OFF, 1, offset added to requester y.
- CLEAR_COLOUR, 3'b000, colour written during the clear sweep.

Ports:
- clock  in  1  system clock (CLOCK_50)
- reset  in  1  synchronous, active-high reset
- wl  in  2  game result; 00 = playing, nonzero = win/lose screen
- b_req  in  1  board drawer requests a burst
- b_x  in  X_W  board pixel x
- b_y  in  Y_W  board pixel y
- b_colour  in  3  board pixel colour
- b_plot  in  1  board pixel valid
- b_done  in  1  board burst finished
- b_grant  out  1  board owns the port
- wl_req  in  1  win/lose drawer requests a burst
- wl_x  in  X_W  win/lose pixel x
- wl_y  in  Y_W  win/lose pixel y
- wl_colour  in  3  win/lose pixel colour
- wl_plot  in  1  win/lose pixel valid
- wl_done  in  1  win/lose burst finished
- wl_grant  out  1  win/lose drawer owns the port
- x_out  out  X_W  to VGA adapter
- y_out  out  Y_W  to VGA adapter
- colour_out  out  3  to VGA adapter
- plot_out  out  1  to VGA adapter
- clearing  out  1  clear sweep in progress

Behaviour:
- States: CLEAR, IDLE, GRANT_B, GRANT_WL.
- Grants decode directly from state: b_grant = (state==GRANT_B), wl_grant = (state==GRANT_WL), clearing = (state==CLEAR).
- Reset (synchronous, active-high):
  - state goes to CLEAR; sweep counters cx=0, cy=0.
  - Registered outputs clear to zero: x_out=0, y_out=0, colour_out=0, plot_out=0.
  - wl_prev captures wl.
  - Reset asserted mid-burst or mid-sweep drops the grant the next cycle and restarts the sweep from (0,0).
- CLEAR:
  - Each cycle, registered outputs are x_out=cx, y_out=cy, colour_out=CLEAR_COLOUR, plot_out=1. No offset is applied.
  - cx increments; at SCREEN_W-1 it wraps to 0 and cy increments.
  - After pixel (SCREEN_W-1, SCREEN_H-1) the state goes to IDLE.
  - The sweep is exactly SCREEN_W*SCREEN_H cycles (19200).
  - A wl change during CLEAR restarts the sweep at (0,0).
- IDLE:
  - If wl!=0 and wl_req, go to GRANT_WL.
  - Else if wl==0 and b_req, go to GRANT_B.
  - b_req is ignored while wl!=0.
  - wl_req is ignored while wl==0.
  - plot_out=0.
- GRANT_x:
  - Each cycle the selected requester's plot is forwarded, registered with 1-cycle latency: x_out = x+X_OFF, y_out = y+Y_OFF. Sums truncate to X_W/Y_W bits, so they wrap.
  - plot_out = requester plot.
  - The unselected requester's inputs are ignored.
  - On done, go to IDLE. A pixel presented with plot in the same cycle as done is still forwarded; the grant drops the next cycle.
  - The requester must hold req until granted. It may drop req once granted; only done ends the burst.
- wl change detect: wl_chg = (wl != wl_prev); wl_prev updates every cycle.
  - On wl_chg in any state, next state is CLEAR with counters zeroed.
  - A granted burst is aborted: the grant drops next cycle and no further pixels from that requester are forwarded.
  - wl_chg takes priority over done and req in the same cycle.
- Requests are never queued. A requester denied in IDLE must keep req asserted.

Decomposition:
- Shared package (minesweeper_pkg):
  - arb_state_t enum {CLEAR, IDLE, GRANT_B, GRANT_WL}
  - SCREEN_W, SCREEN_H, COLOUR_W=3, WL_PLAYING=2'b00
- Sub-module clear_sweeper: raster counter with inputs clock, reset, start, en, and outputs cx, cy, last. The arbiter instantiates one.

Test Plan:
- Reset pulse, no requests:
  - plot_out=1 for exactly 19200 cycles; first pixel (0,0), last (159,119), colour 000.
  - Then plot_out=0, clearing=0, both grants 0.
- After clear, wl=00, b_req=1, then 3 pixels (5,7,c=3'b010), (6,7), (7,7), done with the last:
  - b_grant goes high 1 cycle after req and drops 1 cycle after done.
  - Output pixels are (6,8), (7,8), (8,8), each 1 cycle after input.
- wl=00, wl_req=1:
  - wl_grant stays 0 and plot_out stays 0 for 100 cycles.
- Mid board burst (after 2 pixels), wl goes 00→01:
  - b_grant drops next cycle; clearing=1; the sweep restarts at (0,0).
  - After 19200 cycles a pending wl_req is granted.
- Offset wrap: granted b_x=255, b_y=127 -> x_out=0, y_out=0, plot_out=1.
- Reset asserted during GRANT_WL:
  - Next cycle wl_grant=0, clearing=1, output pixel (0,0).
